pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  PC register and instruction-fetch sequencer; sits directly downstream of the next-PC calculator.
//  Holds the architectural PC and issues one instruction-memory request per instruction.
//  Presents the fetched word to decode, then commits npc_i into the PC when decode is not stalled.
//  npc_i is computed combinationally from pc_o/instr_o, closing the fetch loop.
// PARAMETERS
//  RESET_PC  32'h0000_3000  PC value loaded on reset; bits [1:0] must be 0
// PORTS
//  clk             in   1   single clock, rising edge
//  reset_n         in   1   asynchronous, active-low reset
//  npc_i           in   32  next PC from next-PC calculator, sampled on commit
//  stall_i         in   1   decode/back-end stall; holds the current instruction
//  imem_req_valid  out  1   fetch request valid
//  imem_req_addr   out  32  fetch address (== pc_o)
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_rsp_valid  in   1   fetch response valid
//  imem_rsp_data   in   32  fetched instruction word
//  pc_o            out  32  current PC (feeds next-PC calculator and decode)
//  instr_o         out  32  registered instruction word for pc_o
//  instr_valid_o   out  1   instr_o is valid for pc_o
//  misalign_o      out  1   misaligned-NPC fault, sticky (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async assert, sync release): state=FETCH, pc_o=RESET_PC, instr_o=0, instr_valid_o=0,
//   misalign_o=0. imem_req_valid=0 while reset_n=0.
//  States:
//   FETCH: imem_req_valid=1, imem_req_addr=pc_o. On imem_req_ready -> WAIT.
//   WAIT : imem_req_valid=0. On imem_rsp_valid: instr_o<=imem_rsp_data, instr_valid_o<=1 -> ISSUE.
//   ISSUE: instr_valid_o=1. If !stall_i: pc_o<=npc_i, instr_valid_o<=0 -> FETCH. Else hold all.
//   HALT : entered only with PC_ALIGN_CHECK_EN. No requests; outputs frozen until reset.
//  Handshake rules:
//   - One outstanding request maximum.
//   - imem_req_addr stays stable while imem_req_valid=1 and !imem_req_ready.
//   - imem_rsp_valid in FETCH/ISSUE/HALT is ignored (no outstanding request).
//   - Same-cycle ready+rsp is not legal: the response is never in the acceptance cycle.
//  Latency: minimum 3 cycles per instruction (FETCH with ready, WAIT with rsp next cycle, ISSUE unstalled).
//   Each stalled cycle or memory wait state adds 1 cycle.
//  stall_i affects only ISSUE. In FETCH/WAIT it is ignored; the stall is applied once the word arrives.
//  npc_i is sampled only at the ISSUE commit edge.
//  PC arithmetic: none in this block. Wrap 32'hFFFF_FFFC->0 is the producer's concern.
//  Reset mid-operation (any state, incl. WAIT) -> FETCH at RESET_PC. Instruction memory is reset by the same reset_n.
// CONFIGURATION
//  PC_ALIGN_CHECK_EN defined:
//   - At ISSUE commit, if npc_i[1:0]!=0: pc_o unchanged, misalign_o<=1 (sticky), instr_valid_o<=0 -> HALT.
//  PC_ALIGN_CHECK_EN undefined:
//   - No HALT state; misalign_o tied 0.
//   - pc_o<={npc_i[31:2],2'b00} (low bits dropped silently).
// TESTING
//  1 Reset release, ready=1, rsp next cycle, npc_i=pc+4, no stall -> pc_o 0x3000,0x3004,0x3008 every 3 cycles; imem_req_addr matches.
//  2 imem_req_ready low 4 cycles in FETCH -> imem_req_valid held 1, imem_req_addr stable 0x3000, state stays FETCH.
//  3 stall_i=1 for 5 cycles in ISSUE -> instr_o/pc_o/instr_valid_o frozen; npc_i changes ignored; commit on first unstalled cycle.
//  4 Branch: npc_i=0x3100 at commit -> next imem_req_addr=0x3100; spurious imem_rsp_valid in FETCH -> instr_o unchanged.
//  5 reset_n pulsed low during WAIT -> pc_o=0x3000 immediately, instr_valid_o=0, fresh request after release.
//  6 PC_ALIGN_CHECK_EN: npc_i=0x3102 at commit -> misalign_o=1, pc_o stays, no further requests; without macro pc_o=0x3100.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction-memory request/response bus between fetch unit and imem
interface pc_fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and one-request-per-instruction fetch sequencer
// Optional misaligned-NPC halt enabled by defining PC_ALIGN_CHECK_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            npc_i,
  input  logic                   stall_i,
  pc_fetch_unit_if.master        imem,
  output logic [31:0]            pc_o,
  output logic [31:0]            instr_o,
  output logic                   instr_valid_o,
  output logic                   misalign_o
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_ISSUE
`ifdef PC_ALIGN_CHECK_EN
    , S_HALT
`endif
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   commit;

  assign commit = (state == S_ISSUE) && !stall_i;

`ifdef PC_ALIGN_CHECK_EN
  logic npc_bad;
  assign npc_bad = (npc_i[1:0] != 2'b00);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (imem.imem_req_ready) state_nxt = S_WAIT;
      S_WAIT:  if (imem.imem_rsp_valid) state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (!stall_i) begin
`ifdef PC_ALIGN_CHECK_EN
          state_nxt = npc_bad ? S_HALT : S_FETCH;
`else
          state_nxt = S_FETCH;
`endif
        end
      end
`ifdef PC_ALIGN_CHECK_EN
      S_HALT:  state_nxt = S_HALT;
`endif
      default: state_nxt = S_FETCH;
    endcase
  end

  // Reset forces FETCH asynchronously, so the request must also be gated by reset_n itself.
  always_comb begin
    imem.imem_req_valid = reset_n && (state == S_FETCH);
    imem.imem_req_addr  = pc_o;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_o          <= RESET_PC;
      instr_o       <= 32'h0;
      instr_valid_o <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      misalign_o    <= 1'b0;
`endif
    end else begin
      if ((state == S_WAIT) && imem.imem_rsp_valid) begin
        instr_o       <= imem.imem_rsp_data;
        instr_valid_o <= 1'b1;
      end
      if (commit) begin
        instr_valid_o <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        if (npc_bad) begin
          misalign_o <= 1'b1;
        end else begin
          pc_o <= npc_i;
        end
`else
        pc_o <= npc_i & 32'hFFFF_FFFC;
`endif
      end
    end
  end

`ifndef PC_ALIGN_CHECK_EN
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] npc_i;
  logic        stall_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        misalign_o;

  int          total = 0;
  int          passed = 0;
  int          cyc = 0;
  logic [31:0] exp_pc;
  logic [31:0] last_instr;
  logic [63:0] sb[$];

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .npc_i         (npc_i),
    .stall_i       (stall_i),
    .imem          (bus.master),
    .pc_o          (pc_o),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_1234;
  endfunction

  // One full instruction: optional spurious rsp in FETCH, ready wait states, stall cycles, then commit of npc.
  task automatic fetch_one(input int rdy_delay, input int stall_cyc, input logic [31:0] npc, input bit spurious);
    logic [63:0] e;
    if (spurious) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.imem_rsp_valid = 1'b0;
      total++; if (instr_o !== last_instr) $display("FAIL spurious_rsp instr_o got %h want %h", instr_o, last_instr); else passed++;
    end
    for (int i = 0; i < rdy_delay; i++) begin
      total++; if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, exp_pc}) $display("FAIL req_held got %b/%h want 1/%h", bus.imem_req_valid, bus.imem_req_addr, exp_pc); else passed++;
      @(negedge clk);
    end
    total++; if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, exp_pc}) $display("FAIL req got %b/%h want 1/%h", bus.imem_req_valid, bus.imem_req_addr, exp_pc); else passed++;
    bus.imem_req_ready = 1'b1;
    sb.push_back({exp_pc, mem_word(exp_pc)});
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    total++; if (bus.imem_req_valid !== 1'b0) $display("FAIL wait_no_req got %b want 0", bus.imem_req_valid); else passed++;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = mem_word(bus.imem_req_addr);
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    e = sb.pop_front();
    total++; if ({pc_o, instr_o, instr_valid_o} !== {e, 1'b1}) $display("FAIL issue got %h/%h/%b want %h/%h/1", pc_o, instr_o, instr_valid_o, e[63:32], e[31:0]); else passed++;
    for (int i = 0; i < stall_cyc; i++) begin
      stall_i = 1'b1;
      npc_i   = $urandom;
      @(negedge clk);
      total++; if ({pc_o, instr_o, instr_valid_o, bus.imem_req_valid} !== {e, 2'b10}) $display("FAIL stall_hold got %h/%h/%b/%b want %h/%h/1/0", pc_o, instr_o, instr_valid_o, bus.imem_req_valid, e[63:32], e[31:0]); else passed++;
    end
    stall_i = 1'b0;
    npc_i   = npc;
    @(negedge clk);
    last_instr = e[31:0];
`ifdef PC_ALIGN_CHECK_EN
    if (npc[1:0] != 2'b00) begin
      total++; if ({pc_o, misalign_o, instr_valid_o, bus.imem_req_valid} !== {exp_pc, 3'b100}) $display("FAIL halt got %h/%b/%b/%b want %h/1/0/0", pc_o, misalign_o, instr_valid_o, bus.imem_req_valid, exp_pc); else passed++;
      return;
    end
`endif
    exp_pc = {npc[31:2], 2'b00};
    total++; if ({pc_o, instr_valid_o, misalign_o} !== {exp_pc, 2'b00}) $display("FAIL commit got %h/%b/%b want %h/0/0", pc_o, instr_valid_o, misalign_o, exp_pc); else passed++;
    total++; if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, exp_pc}) $display("FAIL next_req got %b/%h want 1/%h", bus.imem_req_valid, bus.imem_req_addr, exp_pc); else passed++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    npc_i = 32'h0;
    stall_i = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = 32'h0;
    repeat (2) @(negedge clk);
    total++; if ({pc_o, instr_o, instr_valid_o, misalign_o, bus.imem_req_valid} !== {32'h3000, 32'h0, 3'b000}) $display("FAIL reset got %h/%h/%b/%b/%b", pc_o, instr_o, instr_valid_o, misalign_o, bus.imem_req_valid); else passed++;
    reset_n = 1'b1;
    exp_pc = 32'h3000;
    last_instr = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_sequential();
    int c0;
    c0 = cyc;
    for (int i = 0; i < 3; i++) fetch_one(0, 0, exp_pc + 32'd4, 1'b0);
    total++; if (cyc - c0 !== 9) $display("FAIL latency got %0d want 9", cyc - c0); else passed++;
  endtask

  task automatic test_ready_backpressure();
    fetch_one(4, 0, exp_pc + 32'd4, 1'b0);
  endtask

  task automatic test_stall();
    fetch_one(0, 5, exp_pc + 32'd4, 1'b0);
  endtask

  task automatic test_branch();
    fetch_one(1, 0, 32'h0000_3100, 1'b0);
    fetch_one(0, 0, exp_pc + 32'd4, 1'b1);
  endtask

  task automatic test_reset_wait();
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    total++; if (bus.imem_req_valid !== 1'b0) $display("FAIL pre_reset_wait got %b want 0", bus.imem_req_valid); else passed++;
    #2 reset_n = 1'b0;
    #1;
    total++; if ({pc_o, instr_valid_o, bus.imem_req_valid} !== {32'h3000, 2'b00}) $display("FAIL reset_wait got %h/%b/%b want 3000/0/0", pc_o, instr_valid_o, bus.imem_req_valid); else passed++;
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    exp_pc = 32'h3000;
    #1;
    total++; if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, 32'h3000}) $display("FAIL after_reset got %b/%h want 1/3000", bus.imem_req_valid, bus.imem_req_addr); else passed++;
    @(negedge clk);
    fetch_one(0, 0, 32'h0000_3100, 1'b0);
  endtask

  task automatic test_misalign();
    fetch_one(0, 0, 32'h0000_3102, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
    repeat (3) @(negedge clk);
    total++; if ({pc_o, misalign_o, bus.imem_req_valid} !== {32'h3100, 2'b10}) $display("FAIL halt_frozen got %h/%b/%b want 3100/1/0", pc_o, misalign_o, bus.imem_req_valid); else passed++;
`else
    total++; if (pc_o !== 32'h3100) $display("FAIL misalign_drop got %h want 3100", pc_o); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_ready_backpressure();
    test_stall();
    test_branch();
    test_reset_wait();
    test_misalign();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
